instr_fetch_unit: RTL and testbench

Fetch stage that sits directly upstream of the single-cycle I-type datapath's decode/execute logic. It owns the program counter and issues word-addressed reads to a synchronous instruction memory with 1-cycle latency. It buffers returned words with their PCs in a small prefetch FIFO and hands them downstream over a valid/ready handshake. A redirect input lets branch resolution (BEQ/BNE) flush the buffer and restart fetch at a new PC.

---
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input,
// downstream valid/ready handshake and the fetch counter.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus_1;
  logic [15:0]       fetch_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect, redirect_pc,
    output if_valid, if_instr, if_pc, if_pc_plus_1,
    input  if_ready,
    output fetch_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect, redirect_pc,
    input  if_valid, if_instr, if_pc, if_pc_plus_1,
    output if_ready,
    input  fetch_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// buffers {pc, instr} in a credit-controlled prefetch FIFO.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  instr_fetch_unit_if.master bus
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_q, pend_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [DATA_W-1:0] instr_d [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [ADDR_W-1:0] pc_d [DEPTH];

  logic           pop;
  logic           push;
  logic           issue;
  logic [CW1-1:0] credit;

  always_comb begin
    pop    = (count_q != '0) & bus.if_ready;
    push   = pend_q & ~bus.redirect;
    // Slots already owed: buffered + in flight, minus what leaves now.
    credit = CW1'(count_q) + CW1'(pend_q) - CW1'(pop);
    issue  = ~reset &
             (bus.redirect | (credit < CW1'(DEPTH)));

    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pend_d     = pend_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fcnt_d     = fcnt_q;
    instr_d    = instr_q;
    pc_d       = pc_q;

    if (bus.redirect) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pend_d     = 1'b1;
      pend_pc_d  = bus.redirect_pc;
      fetch_pc_d = bus.redirect_pc + ADDR_W'(1);
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = bus.imem_rdata;
        pc_d[wr_ptr_q]    = pend_pc_q;
        wr_ptr_d          = wr_ptr_q + PW'(1);
        fcnt_d            = fcnt_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      pend_d  = issue;
      if (issue) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pend_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fcnt_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fcnt_q     <= fcnt_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = bus.redirect ? bus.redirect_pc
                                         : fetch_pc_q;
  assign bus.if_valid     = (count_q != '0);
  assign bus.if_instr     = instr_q[rd_ptr_q];
  assign bus.if_pc        = pc_q[rd_ptr_q];
  assign bus.if_pc_plus_1 = pc_q[rd_ptr_q] + ADDR_W'(1);
  assign bus.fetch_count  = fcnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit (ADDR_W=8 so PC wrap is reachable).
// Stimulus queues expected deliveries; a monitor pops them on each transfer.
module tb_instr_fetch_unit;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic [AW-1:0] pcp1;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb [$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;
  int   nreq;

  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(2), .RESET_PC('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: mem[k] = 0x1000_0000 + k, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_req)
      bus.imem_rdata <= 32'h1000_0000 + {24'h0, bus.imem_addr};
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic exp_push(input logic [AW-1:0] pc,
                          input logic [DW-1:0] instr,
                          input logic [AW-1:0] pcp1);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.pcp1  = pcp1;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the start of cycle 0 with reset released.
  task automatic do_reset();
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.if_ready    = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_fetch_count", {16'b0, bus.fetch_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  always begin
    @(negedge clk);
    #4;
    if (!reset && !bus.redirect && bus.if_valid && bus.if_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_delivery: got pc %h want none",
                 bus.if_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("if_pc", {24'b0, bus.if_pc}, {24'b0, mon_e.pc});
        chk("if_instr", bus.if_instr, mon_e.instr);
        chk("if_pc_plus_1", {24'b0, bus.if_pc_plus_1},
            {24'b0, mon_e.pcp1});
      end
    end
  end

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.if_ready     = 1'b0;
    bus.imem_rdata   = '0;

    // 1: streaming from reset, 6 deliveries in cycles 2..7
    do_reset();
    bus.if_ready = 1'b1;
    for (int k = 0; k < 6; k++)
      exp_push(AW'(k), 32'h1000_0000 + k, AW'(k + 1));
    #4;
    chk("t1_addr_c0", {24'b0, bus.imem_addr}, 32'h0);
    chk("t1_req_c0", {31'b0, bus.imem_req}, 32'd1);
    chk("t1_valid_c0", {31'b0, bus.if_valid}, 32'd0);
    cyc(1);
    #4;
    chk("t1_addr_c1", {24'b0, bus.imem_addr}, 32'h1);
    chk("t1_valid_c1", {31'b0, bus.if_valid}, 32'd0);
    cyc(1);
    #4;
    chk("t1_valid_c2", {31'b0, bus.if_valid}, 32'd1);
    cyc(6);
    bus.if_ready = 1'b0;
    cyc(2);
    #4;
    chk("t1_fetch_count", {16'b0, bus.fetch_count}, 32'd8);
    chk("t1_req_full", {31'b0, bus.imem_req}, 32'd0);

    // 2: backpressure from reset, then drain 0..3
    do_reset();
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      #4;
      nreq += int'(bus.imem_req);
      if (i == 3 || i == 5) begin
        chk("t2_hold_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("t2_hold_pc", {24'b0, bus.if_pc}, 32'h0);
      end
      @(negedge clk);
    end
    chk("t2_req_count", nreq, 32'd2);
    for (int k = 0; k < 4; k++)
      exp_push(AW'(k), 32'h1000_0000 + k, AW'(k + 1));
    bus.if_ready = 1'b1;
    cyc(4);
    bus.if_ready = 1'b0;
    cyc(2);

    // 3: redirect to 0x1F while streaming
    do_reset();
    bus.if_ready = 1'b1;
    exp_push(8'h00, 32'h1000_0000, 8'h01);
    exp_push(8'h01, 32'h1000_0001, 8'h02);
    exp_push(8'h02, 32'h1000_0002, 8'h03);
    cyc(5);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h1F;
    exp_push(8'h1F, 32'h1000_001F, 8'h20);
    exp_push(8'h20, 32'h1000_0020, 8'h21);
    exp_push(8'h21, 32'h1000_0021, 8'h22);
    #4;
    chk("t3_redir_addr", {24'b0, bus.imem_addr}, 32'h1F);
    chk("t3_redir_req", {31'b0, bus.imem_req}, 32'd1);
    cyc(1);
    bus.redirect = 1'b0;
    #4;
    chk("t3_gap_valid", {31'b0, bus.if_valid}, 32'd0);
    cyc(1);
    #4;
    chk("t3_first_pc", {24'b0, bus.if_pc}, 32'h1F);
    chk("t3_first_pcp1", {24'b0, bus.if_pc_plus_1}, 32'h20);
    cyc(3);
    bus.if_ready = 1'b0;
    #4;
    chk("t3_fetch_count", {16'b0, bus.fetch_count}, 32'd8);
    cyc(2);

    // 4: FIFO full, pop and redirect in the same cycle
    do_reset();
    cyc(4);
    #4;
    chk("t4_full_valid", {31'b0, bus.if_valid}, 32'd1);
    chk("t4_full_req", {31'b0, bus.imem_req}, 32'd0);
    @(negedge clk);
    bus.if_ready    = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    exp_push(8'h40, 32'h1000_0040, 8'h41);
    exp_push(8'h41, 32'h1000_0041, 8'h42);
    #4;
    chk("t4_redir_addr", {24'b0, bus.imem_addr}, 32'h40);
    cyc(1);
    bus.redirect = 1'b0;
    #4;
    chk("t4_flushed", {31'b0, bus.if_valid}, 32'd0);
    cyc(3);
    bus.if_ready = 1'b0;
    cyc(2);

    // 5: PC wrap at ADDR_W=8
    do_reset();
    cyc(3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFE;
    bus.if_ready    = 1'b1;
    exp_push(8'hFE, 32'h1000_00FE, 8'hFF);
    exp_push(8'hFF, 32'h1000_00FF, 8'h00);
    exp_push(8'h00, 32'h1000_0000, 8'h01);
    exp_push(8'h01, 32'h1000_0001, 8'h02);
    cyc(1);
    bus.redirect = 1'b0;
    cyc(5);
    bus.if_ready = 1'b0;
    cyc(2);

    // 6: asynchronous reset mid-stream
    do_reset();
    bus.if_ready = 1'b1;
    exp_push(8'h00, 32'h1000_0000, 8'h01);
    exp_push(8'h01, 32'h1000_0001, 8'h02);
    exp_push(8'h02, 32'h1000_0002, 8'h03);
    cyc(5);
    chk("t6_pre_count", {16'b0, bus.fetch_count}, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("t6_async_req", {31'b0, bus.imem_req}, 32'd0);
    chk("t6_async_count", {16'b0, bus.fetch_count}, 32'd0);
    cyc(2);
    reset = 1'b0;
    bus.if_ready = 1'b1;
    exp_push(8'h00, 32'h1000_0000, 8'h01);
    exp_push(8'h01, 32'h1000_0001, 8'h02);
    #4;
    chk("t6_restart_addr", {24'b0, bus.imem_addr}, 32'h0);
    cyc(4);
    bus.if_ready = 1'b0;
    cyc(3);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
